// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector execute sequencer.
// Holds the SEW/LMUL encodings, sequencer states and the body byte-count helper.
package riscv_v_pkg;

  localparam int unsigned VLEN_DEF = 128;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    LMUL_1 = 2'd0,
    LMUL_2 = 2'd1,
    LMUL_4 = 2'd2,
    LMUL_8 = 2'd3
  } lmul_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Active body bytes of a register group; vl beyond VLMAX is clamped.
  function automatic int unsigned body_bytes(input int unsigned vlen,
                                             input int unsigned vl,
                                             input sew_e        sew,
                                             input lmul_e       lmul);
    int unsigned vlmax;
    vlmax = ((vlen / 8) << lmul) >> sew;
    return ((vl < vlmax) ? vl : vlmax) << sew;
  endfunction

endpackage

// File: rtl/riscv_v_chunk_mask_gen.sv
// Per-byte body mask for one VLEN-wide chunk of a register group.
module riscv_v_chunk_mask_gen
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN = VLEN_DEF,
  parameter int unsigned B_W  = $clog2(VLEN) + 1
) (
  input  logic [2:0]        chunk_idx_i,
  input  logic [B_W-1:0]    bytes_i,
  output logic [VLEN/8-1:0] byte_en_o
);

  localparam int unsigned BE_W = VLEN / 8;

  always_comb begin
    byte_en_o = '0;
    for (int unsigned j = 0; j < BE_W; j++) begin
      byte_en_o[j] = ((32'(chunk_idx_i) * BE_W) + j) < 32'(bytes_i);
    end
  end

endmodule

// File: rtl/riscv_v_exe_seq.sv
// Vector execute sequencer: splits an LMUL register group into VLEN chunks,
// issues one chunk per cycle and tracks ALU latency to generate writebacks.
module riscv_v_exe_seq
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN    = VLEN_DEF,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned VL_W    = $clog2(VLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [VL_W-1:0]   issue_vl,
  input  logic [1:0]        issue_sew,
  input  logic [1:0]        issue_lmul,
  input  logic [4:0]        issue_vd,
  input  logic [4:0]        issue_vs1,
  input  logic [4:0]        issue_vs2,
  input  logic              issue_is_mul,
  input  logic              issue_is_reduct,
  output logic              alu_valid,
  output logic [4:0]        alu_vd,
  output logic [4:0]        alu_vs1,
  output logic [4:0]        alu_vs2,
  output logic [VLEN/8-1:0] alu_byte_en,
  output logic              alu_first,
  output logic              alu_last,
  output logic              wb_valid,
  output logic [4:0]        wb_vd,
  output logic [VLEN/8-1:0] wb_byte_en,
  output logic              illegal,
  output logic              done,
  output logic              busy
);

  localparam int unsigned BE_W   = VLEN / 8;
  localparam int unsigned B_W    = $clog2(VLEN) + 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BE_SH  = $clog2(BE_W);
  localparam int unsigned IDX_PW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  sew_e             sew_q, sew_d;
  logic [B_W-1:0]   bytes_q, bytes_d;
  logic [CNT_W-1:0] nch_q, nch_d;
  logic             mul_q, mul_d, red_q, red_d;

  logic             alu_valid_q, alu_valid_d, alu_first_q, alu_first_d, alu_last_q, alu_last_d;
  logic [4:0]       alu_vd_q, alu_vd_d, alu_vs1_q, alu_vs1_d, alu_vs2_q, alu_vs2_d;
  logic [BE_W-1:0]  alu_be_q, alu_be_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_vd_q, wb_vd_d;
  logic [BE_W-1:0]  wb_be_q, wb_be_d;
  logic             illegal_q, illegal_d, done_q, done_d, busy_q;

  // Writeback latency line; entries are inserted MUL_LAT-L stages from the tail.
  logic             pv_q  [MUL_LAT];
  logic             pv_d  [MUL_LAT];
  logic [4:0]       pvd_q [MUL_LAT];
  logic [4:0]       pvd_d [MUL_LAT];
  logic [BE_W-1:0]  pbe_q [MUL_LAT];
  logic [BE_W-1:0]  pbe_d [MUL_LAT];

  logic             hs, hs_mis, idle, issue_chunk, chunk_last, pipe_busy;
  logic [4:0]       lmask;
  logic [B_W-1:0]   hs_bytes, cur_bytes;
  logic [CNT_W-1:0] hs_nch, cur_nch;
  logic [2:0]       cur_idx;
  logic [4:0]       cur_vd, cur_vs1, cur_vs2;
  logic [1:0]       cur_sew;
  logic             cur_mul, cur_red;
  logic [BE_W-1:0]  mg_be, red_be;
  logic [IDX_PW-1:0] ins_idx;

  assign idle        = (state_q == S_IDLE);
  assign issue_ready = idle & ~flush;
  assign hs          = issue_valid & issue_ready;
  assign lmask       = 5'((32'd1 << issue_lmul) - 32'd1);
  assign hs_mis      = |((issue_vd | issue_vs1 | issue_vs2) & lmask);
  assign hs_bytes    = B_W'(body_bytes(VLEN, 32'(issue_vl), sew_e'(issue_sew), lmul_e'(issue_lmul)));
  assign hs_nch      = CNT_W'((32'(hs_bytes) + BE_W - 32'd1) >> BE_SH);

  // Chunk 0 is launched straight from the issue port; later chunks from latched fields.
  assign cur_idx   = idle ? 3'd0 : cnt_q[2:0];
  assign cur_bytes = idle ? hs_bytes : bytes_q;
  assign cur_nch   = idle ? hs_nch : nch_q;
  assign cur_vd    = idle ? issue_vd : vd_q;
  assign cur_vs1   = idle ? issue_vs1 : vs1_q;
  assign cur_vs2   = idle ? issue_vs2 : vs2_q;
  assign cur_sew   = idle ? issue_sew : sew_q;
  assign cur_mul   = idle ? issue_is_mul : mul_q;
  assign cur_red   = idle ? issue_is_reduct : red_q;
  assign chunk_last = ((CNT_W'(cur_idx) + CNT_W'(1)) == cur_nch);
  assign ins_idx   = cur_mul ? IDX_PW'(0) : IDX_PW'(MUL_LAT - 1);

  riscv_v_chunk_mask_gen #(
    .VLEN (VLEN),
    .B_W  (B_W)
  ) u_mask (
    .chunk_idx_i (cur_idx),
    .bytes_i     (cur_bytes),
    .byte_en_o   (mg_be)
  );

  always_comb begin
    red_be    = '0;
    pipe_busy = 1'b0;
    for (int unsigned j = 0; j < BE_W; j++) begin
      red_be[j] = (j < (32'd1 << cur_sew));
    end
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      pipe_busy = pipe_busy | pv_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vd_d        = vd_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    sew_d       = sew_q;
    bytes_d     = bytes_q;
    nch_d       = nch_q;
    mul_d       = mul_q;
    red_d       = red_q;
    issue_chunk = 1'b0;
    alu_valid_d = 1'b0;
    alu_vd_d    = '0;
    alu_vs1_d   = '0;
    alu_vs2_d   = '0;
    alu_be_d    = '0;
    alu_first_d = 1'b0;
    alu_last_d  = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    wb_valid_d  = pv_q[MUL_LAT-1];
    wb_vd_d     = pvd_q[MUL_LAT-1];
    wb_be_d     = pbe_q[MUL_LAT-1];
    pv_d[0]     = 1'b0;
    pvd_d[0]    = '0;
    pbe_d[0]    = '0;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pvd_d[i] = pvd_q[i-1];
      pbe_d[i] = pbe_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          vd_d    = issue_vd;
          vs1_d   = issue_vs1;
          vs2_d   = issue_vs2;
          sew_d   = sew_e'(issue_sew);
          bytes_d = hs_bytes;
          nch_d   = hs_nch;
          mul_d   = issue_is_mul;
          red_d   = issue_is_reduct;
          if (hs_mis) begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end else if (hs_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            issue_chunk = 1'b1;
            cnt_d       = CNT_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q < nch_q) begin
          issue_chunk = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      issue_chunk = 1'b0;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
    end

    if (issue_chunk) begin
      alu_valid_d = 1'b1;
      alu_vd_d    = cur_vd + 5'(cur_idx);
      alu_vs1_d   = cur_vs1 + 5'(cur_idx);
      alu_vs2_d   = cur_vs2 + 5'(cur_idx);
      alu_be_d    = mg_be;
      alu_first_d = (cur_idx == 3'd0);
      alu_last_d  = chunk_last;
      // A reduction only writes back once, after its final chunk.
      if (!cur_red || chunk_last) begin
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
          if (IDX_PW'(i) == ins_idx) begin
            pv_d[i]  = 1'b1;
            pvd_d[i] = cur_red ? cur_vd : alu_vd_d;
            pbe_d[i] = cur_red ? red_be : mg_be;
          end
        end
      end
    end

    if (flush) begin
      wb_valid_d = 1'b0;
      wb_vd_d    = '0;
      wb_be_d    = '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        pv_d[i]  = 1'b0;
        pvd_d[i] = '0;
        pbe_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      sew_q       <= SEW_8;
      bytes_q     <= '0;
      nch_q       <= '0;
      mul_q       <= 1'b0;
      red_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_vd_q    <= '0;
      alu_vs1_q   <= '0;
      alu_vs2_q   <= '0;
      alu_be_q    <= '0;
      alu_first_q <= 1'b0;
      alu_last_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_vd_q     <= '0;
      wb_be_q     <= '0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pvd_q[i] <= '0;
        pbe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vd_q        <= vd_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      sew_q       <= sew_d;
      bytes_q     <= bytes_d;
      nch_q       <= nch_d;
      mul_q       <= mul_d;
      red_q       <= red_d;
      alu_valid_q <= alu_valid_d;
      alu_vd_q    <= alu_vd_d;
      alu_vs1_q   <= alu_vs1_d;
      alu_vs2_q   <= alu_vs2_d;
      alu_be_q    <= alu_be_d;
      alu_first_q <= alu_first_d;
      alu_last_q  <= alu_last_d;
      wb_valid_q  <= wb_valid_d;
      wb_vd_q     <= wb_vd_d;
      wb_be_q     <= wb_be_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
      busy_q      <= (state_d != S_IDLE);
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        pv_q[i]  <= pv_d[i];
        pvd_q[i] <= pvd_d[i];
        pbe_q[i] <= pbe_d[i];
      end
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_vd      = alu_vd_q;
  assign alu_vs1     = alu_vs1_q;
  assign alu_vs2     = alu_vs2_q;
  assign alu_byte_en = alu_be_q;
  assign alu_first   = alu_first_q;
  assign alu_last    = alu_last_q;
  assign wb_valid    = wb_valid_q;
  assign wb_vd       = wb_vd_q;
  assign wb_byte_en  = wb_be_q;
  assign illegal     = illegal_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_riscv_v_exe_seq.sv
// Scoreboard bench for riscv_v_exe_seq: directed scenarios then randomized ops,
// each expected ALU beat, writeback and completion is timestamped by cycle.
module tb_riscv_v_exe_seq;

  localparam int unsigned VLEN    = 128;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned VL_W    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [7:0]  issue_vl = '0;
  logic [1:0]  issue_sew = '0;
  logic [1:0]  issue_lmul = '0;
  logic [4:0]  issue_vd = '0;
  logic [4:0]  issue_vs1 = '0;
  logic [4:0]  issue_vs2 = '0;
  logic        issue_is_mul = 1'b0;
  logic        issue_is_reduct = 1'b0;
  logic        alu_valid, alu_first, alu_last, wb_valid, illegal, done, busy;
  logic [4:0]  alu_vd, alu_vs1, alu_vs2, wb_vd;
  logic [15:0] alu_byte_en, wb_byte_en;

  always #5 clk = ~clk;

  riscv_v_exe_seq #(.VLEN(VLEN), .MUL_LAT(MUL_LAT), .VL_W(VL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vl(issue_vl), .issue_sew(issue_sew), .issue_lmul(issue_lmul),
    .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
    .issue_is_mul(issue_is_mul), .issue_is_reduct(issue_is_reduct),
    .alu_valid(alu_valid), .alu_vd(alu_vd), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2),
    .alu_byte_en(alu_byte_en), .alu_first(alu_first), .alu_last(alu_last),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .wb_byte_en(wb_byte_en),
    .illegal(illegal), .done(done), .busy(busy)
  );

  typedef struct { int cyc; int vd; int vs1; int vs2; logic [15:0] be; bit first; bit last; } alu_t;
  typedef struct { int cyc; int vd; logic [15:0] be; } wb_t;
  typedef struct { int cyc; bit ill; } done_t;

  alu_t  q_alu[$];
  wb_t   q_wb[$];
  done_t q_done[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int busy_lo = 1;
  int busy_hi = 0;
  int next_free = 0;

  alu_t  ea;
  wb_t   ew;
  done_t ed;
  bit    eb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Mask of the lowest nb bytes of a 16-byte chunk.
  function automatic logic [15:0] low_bytes(input int nb);
    logic [16:0] t;
    if (nb <= 0) return 16'h0000;
    if (nb >= 16) return 16'hFFFF;
    t = (17'd1 << nb) - 17'd1;
    return t[15:0];
  endfunction

  // Monitor: pops expected events scheduled for this cycle and compares.
  always @(negedge clk) begin
    if (mon_en) begin
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", 32'(busy), 32'(eb));
      chk("issue_ready", 32'(issue_ready), 32'(!eb && !flush));

      if (q_alu.size() > 0 && q_alu[0].cyc <= cyc) begin
        ea = q_alu.pop_front();
        chk("alu_valid", 32'(alu_valid), 32'd1);
        if (alu_valid) begin
          chk("alu_vd", 32'(alu_vd), 32'(ea.vd));
          chk("alu_vs1", 32'(alu_vs1), 32'(ea.vs1));
          chk("alu_vs2", 32'(alu_vs2), 32'(ea.vs2));
          chk("alu_byte_en", 32'(alu_byte_en), 32'(ea.be));
          chk("alu_first", 32'(alu_first), 32'(ea.first));
          chk("alu_last", 32'(alu_last), 32'(ea.last));
        end
      end else if (alu_valid) begin
        chk("alu_valid_unexpected", 32'(alu_valid), 32'd0);
      end

      if (q_wb.size() > 0 && q_wb[0].cyc <= cyc) begin
        ew = q_wb.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'd1);
        if (wb_valid) begin
          chk("wb_vd", 32'(wb_vd), 32'(ew.vd));
          chk("wb_byte_en", 32'(wb_byte_en), 32'(ew.be));
        end
      end else if (wb_valid) begin
        chk("wb_valid_unexpected", 32'(wb_valid), 32'd0);
      end

      if (q_done.size() > 0 && q_done[0].cyc <= cyc) begin
        ed = q_done.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("illegal", 32'(illegal), 32'(ed.ill));
      end else if (done || illegal) begin
        chk("done_illegal_unexpected", {30'd0, done, illegal}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic purge(input int f);
    while (q_alu.size() > 0 && q_alu[q_alu.size()-1].cyc > f) q_alu.delete(q_alu.size()-1);
    while (q_wb.size() > 0 && q_wb[q_wb.size()-1].cyc > f) q_wb.delete(q_wb.size()-1);
    while (q_done.size() > 0 && q_done[q_done.size()-1].cyc > f) q_done.delete(q_done.size()-1);
  endtask

  // Issue one op at the first idle cycle; optionally abort it abort_off cycles later.
  task automatic run_op(input int vl, input int sew, input int lmul, input int vd,
                        input int vs1, input int vs2, input bit mul, input bit red,
                        input int abort_off, input bit abort_rst);
    int t, grp, vlmax, ev, b, n, lat, f, k;
    bit mis;
    while (cyc < next_free) step();
    t = cyc;
    issue_valid     = 1'b1;
    issue_vl        = 8'(vl);
    issue_sew       = 2'(sew);
    issue_lmul      = 2'(lmul);
    issue_vd        = 5'(vd);
    issue_vs1       = 5'(vs1);
    issue_vs2       = 5'(vs2);
    issue_is_mul    = mul;
    issue_is_reduct = red;

    grp   = 1 << lmul;
    mis   = (vd % grp != 0) || (vs1 % grp != 0) || (vs2 % grp != 0);
    vlmax = (16 * grp) / (1 << sew);
    ev    = (vl < vlmax) ? vl : vlmax;
    b     = ev * (1 << sew);
    n     = (b + 15) / 16;
    lat   = mul ? int'(MUL_LAT) : 1;

    if (mis || b == 0) begin
      q_done.push_back('{cyc: t + 1, ill: mis});
      busy_lo   = t + 1;
      busy_hi   = t;
      next_free = t + 1;
    end else begin
      for (k = 0; k < n; k++) begin
        q_alu.push_back('{cyc: t + 1 + k, vd: vd + k, vs1: vs1 + k, vs2: vs2 + k,
                          be: low_bytes(b - 16 * k), first: (k == 0), last: (k == n - 1)});
        if (!red) q_wb.push_back('{cyc: t + 1 + k + lat, vd: vd + k, be: low_bytes(b - 16 * k)});
      end
      if (red) q_wb.push_back('{cyc: t + n + lat, vd: vd, be: low_bytes(1 << sew)});
      q_done.push_back('{cyc: t + n + lat + 1, ill: 1'b0});
      busy_lo   = t + 1;
      busy_hi   = t + n + lat;
      next_free = t + n + lat + 1;
    end

    step();
    issue_valid = 1'b0;
    issue_vl    = 8'($urandom);
    issue_vd    = 5'($urandom);

    if (abort_off > 0 && !mis && b > 0) begin
      f = t + ((abort_off < n + lat) ? abort_off : n + lat);
      while (cyc < f) step();
      if (abort_rst) begin
        rst = 1'b1;
      end else begin
        flush       = 1'b1;
        issue_valid = 1'b1;
      end
      purge(f);
      busy_hi   = f;
      next_free = f + 1;
      step();
      rst         = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      if (abort_rst) begin
        chk("rst_alu_vd", 32'(alu_vd), 32'd0);
        chk("rst_alu_byte_en", 32'(alu_byte_en), 32'd0);
        chk("rst_wb_vd", 32'(wb_vd), 32'd0);
        chk("rst_wb_byte_en", 32'(wb_byte_en), 32'd0);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vl, sew, lmul, m, vd, vs1, vs2, ab;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_alu_valid", 32'(alu_valid), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_alu_fields", {11'd0, alu_vd, alu_vs1, alu_vs2, alu_first, alu_last}, 32'd0);
    chk("reset_masks", {alu_byte_en, wb_byte_en}, 32'd0);
    chk("reset_wb_vd", 32'(wb_vd), 32'd0);
    rst = 1'b0;
    step();
    mon_en    = 1'b1;
    next_free = cyc;

    run_op(10, 0, 0, 4, 4, 4, 1'b0, 1'b0, 0, 1'b0);
    run_op(18, 2, 3, 8, 16, 24, 1'b0, 1'b0, 0, 1'b0);
    run_op(16, 1, 1, 2, 4, 6, 1'b1, 1'b0, 0, 1'b0);
    run_op(0, 2, 1, 4, 6, 8, 1'b0, 1'b0, 0, 1'b0);
    run_op(20, 0, 2, 3, 4, 8, 1'b0, 1'b0, 0, 1'b0);
    run_op(32, 0, 1, 6, 8, 10, 1'b0, 1'b1, 0, 1'b0);
    run_op(64, 0, 2, 8, 12, 16, 1'b1, 1'b0, 2, 1'b0);
    run_op(40, 1, 2, 0, 4, 8, 1'b0, 1'b0, 0, 1'b0);
    run_op(200, 0, 0, 1, 2, 3, 1'b0, 1'b0, 0, 1'b0);
    run_op(128, 3, 3, 0, 8, 16, 1'b1, 1'b0, 4, 1'b1);
    run_op(128, 0, 3, 24, 16, 8, 1'b1, 1'b1, 0, 1'b0);

    // flush together with a valid offer while idle must not be accepted
    while (cyc < next_free) step();
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_vl    = 8'd16;
    issue_sew   = 2'd0;
    issue_lmul  = 2'd0;
    issue_vd    = 5'd5;
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    next_free   = cyc;

    for (int i = 0; i < 80; i++) begin
      vl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 130));
      sew  = int'($urandom_range(0, 3));
      lmul = int'($urandom_range(0, 3));
      m    = (1 << lmul) - 1;
      vd   = int'($urandom_range(0, 31)) & ~m;
      vs1  = int'($urandom_range(0, 31)) & ~m;
      vs2  = int'($urandom_range(0, 31)) & ~m;
      if (lmul > 0 && $urandom_range(0, 9) == 0) vs1 = vs1 | 1;
      ab   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 12)) : 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      run_op(vl, sew, lmul, vd, vs1, vs2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             ab, 1'($urandom_range(0, 4) == 0));
    end

    while (cyc < next_free + int'(MUL_LAT) + 3) step();
    chk("scoreboard_drained", 32'(q_alu.size() + q_wb.size() + q_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
